job_initiator: RTL and testbench
================================

Name: job_initiator

Overview:
- Initiator side of the enter/exit pulse handshake used between the controller and worker FSMs in this design.
- On `go` it issues a batch of `num_jobs` start pulses to an external worker, one at a time. Each time it waits for the worker's one-cycle `worker_done`.
- It applies a per-job timeout with bounded retries, counts completed jobs, and reports batch completion or failure with one-cycle pulses.

Parameters:
- JOB_W, 4, width of num_jobs and jobs_ok.
- TIMEOUT, 12, maximum WAIT cycles per attempt; legal range 2..255.
- MAX_RETRY, 2, re-issues allowed per job after a timeout; 0 means no retry.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- go  input  1  batch request; sampled only in IDLE.
- num_jobs  input  JOB_W  job count; latched when go is accepted.
- worker_done  input  1  one-cycle completion pulse from the worker.
- start  output  1  one-cycle pulse to the worker, one per attempt.
- busy  output  1  high in every state except IDLE.
- batch_done  output  1  one-cycle pulse: all jobs completed.
- err  output  1  one-cycle pulse: a job exhausted its retries.
- jobs_ok  output  JOB_W  jobs completed in the current or last batch.
- retries  output  2  retries used on the current job.

Behaviour:
- Single clock domain. All outputs are registered and decoded from next-state, so an output is high in the same cycle its state is current.
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - start, busy, batch_done, err, jobs_ok, retries and the internal timer all go to 0.
  - Reset applies in any state and aborts an in-flight job with no pulse.
- States: IDLE, ISSUE, WAIT, FINISH, FAIL.
- IDLE:
  - go=1 and num_jobs!=0: latch num_jobs, clear jobs_ok and retries, go to ISSUE.
  - go=1 and num_jobs==0: go to FINISH directly; no start is issued.
  - go=0: stay in IDLE.
- ISSUE:
  - Lasts exactly 1 cycle with start=1, then goes to WAIT with timer=0.
  - worker_done seen in ISSUE is ignored.
- WAIT:
  - worker_done=1: jobs_ok+1, retries:=0.
    - If jobs_ok+1 equals the latched count, go to FINISH.
    - Otherwise go to ISSUE.
  - worker_done=0 and timer==TIMEOUT-1: timeout.
    - If retries<MAX_RETRY: retries+1, go to ISSUE.
    - Otherwise go to FAIL.
  - Otherwise timer+1.
  - worker_done in the same cycle as the timeout condition counts as success.
- FINISH: batch_done=1 for 1 cycle, then IDLE. jobs_ok holds its value until the next accepted go.
- FAIL: err=1 for 1 cycle, then IDLE. jobs_ok holds the number of jobs completed before the failure.
- Input filtering:
  - go while busy is ignored, not queued.
  - worker_done outside WAIT is ignored.
- Latency and bounds:
  - go at edge N gives start high in cycle N+1, and WAIT begins at cycle N+2.
  - The fastest per-job loop is 2 cycles (ISSUE plus WAIT with an immediate done).
  - A job's worst case is (MAX_RETRY+1)*(TIMEOUT+1) cycles.
- jobs_ok does not wrap: the maximum count is 2^JOB_W-1, equal to the largest num_jobs value.
- retries is 2 bits; MAX_RETRY>3 is illegal and must be flagged by a simulation-only check.
- A simulation-only state-name register is provided, as in the other FSMs in this design.

Test Plan:
- Reset, then go=1 with num_jobs=1; worker_done on the 3rd WAIT cycle → start in cycle 1 only, batch_done high one cycle later, jobs_ok=1, busy low afterwards.
- num_jobs=3, worker_done on the 1st WAIT cycle each time → exactly 3 start pulses spaced 2 cycles apart, then batch_done, jobs_ok=3.
- num_jobs=2, TIMEOUT=12, MAX_RETRY=2; first job silent for 12 WAIT cycles, then done on its retry → start re-issued, retries=1 then 0, batch_done with jobs_ok=2, no err.
- num_jobs=2, worker never responds → 3 start pulses 13 cycles apart, then err for 1 cycle, jobs_ok=0, no batch_done.
- go with num_jobs=0 → batch_done the next cycle, no start.
- Spurious worker_done during ISSUE/IDLE plus a go pulse while busy → both ignored, counts unchanged.
- rst=1 mid-WAIT → all outputs 0 next cycle, state IDLE, no pulse.

Source files
------------

// File: rtl/job_initiator.sv
// Batch job initiator: issues num_jobs start pulses to a worker, one at a time,
// with a per-attempt timeout, bounded retries and done/error completion pulses.
module job_initiator #(
  parameter int unsigned JOB_W     = 4,
  parameter int unsigned TIMEOUT   = 12,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [JOB_W-1:0] num_jobs,
  input  logic             worker_done,
  output logic             start,
  output logic             busy,
  output logic             batch_done,
  output logic             err,
  output logic [JOB_W-1:0] jobs_ok,
  output logic [1:0]       retries
);

  if (MAX_RETRY > 3) begin : g_bad_max_retry
    $error("job_initiator: MAX_RETRY=%0d does not fit the 2-bit retries counter", MAX_RETRY);
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("job_initiator: TIMEOUT=%0d outside 2..255", TIMEOUT);
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINISH, FAIL} state_t;

  state_t           state, state_nx;
  logic [JOB_W-1:0] count, count_nx;
  logic [JOB_W-1:0] jobs_ok_nx;
  logic [JOB_W-1:0] jobs_inc;
  logic [1:0]       retries_nx;
  logic [7:0]       timer, timer_nx;
  logic [47:0]      state_name;

  assign jobs_inc = jobs_ok + JOB_W'(1);

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    jobs_ok_nx = jobs_ok;
    retries_nx = retries;
    timer_nx   = timer;
    case (state)
      IDLE: begin
        if (go) begin
          jobs_ok_nx = '0;
          retries_nx = '0;
          if (num_jobs != '0) begin
            count_nx = num_jobs;
            state_nx = ISSUE;
          end else begin
            state_nx = FINISH;
          end
        end
      end
      ISSUE: begin
        timer_nx = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        // A done arriving on the timeout cycle wins over the timeout.
        if (worker_done) begin
          jobs_ok_nx = jobs_inc;
          retries_nx = '0;
          state_nx   = (jobs_inc == count) ? FINISH : ISSUE;
        end else if (timer == 8'(TIMEOUT - 1)) begin
          if (retries < 2'(MAX_RETRY)) begin
            retries_nx = retries + 2'd1;
            state_nx   = ISSUE;
          end else begin
            state_nx = FAIL;
          end
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      FINISH:  state_nx = IDLE;
      FAIL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each pulse coincides with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      jobs_ok    <= '0;
      retries    <= '0;
      timer      <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      jobs_ok    <= jobs_ok_nx;
      retries    <= retries_nx;
      timer      <= timer_nx;
      start      <= (state_nx == ISSUE);
      busy       <= (state_nx != IDLE);
      batch_done <= (state_nx == FINISH);
      err        <= (state_nx == FAIL);
    end
  end

  always_comb begin
    state_name = "?";
    case (state)
      IDLE:    state_name = "IDLE";
      ISSUE:   state_name = "ISSUE";
      WAIT:    state_name = "WAIT";
      FINISH:  state_name = "FINISH";
      FAIL:    state_name = "FAIL";
      default: state_name = "?";
    endcase
  end

endmodule

// File: tb/tb_job_initiator.sv
// Bench for job_initiator: per-scenario tasks compare a per-cycle output vector
// against a timeline computed from per-attempt worker response delays.
module tb_job_initiator;

  localparam int unsigned JW = 4;
  localparam int unsigned TO = 12;
  localparam int unsigned MR = 2;
  localparam int          NC = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [JW-1:0] num_jobs;
  logic          worker_done;
  logic          start, busy, batch_done, err;
  logic [JW-1:0] jobs_ok;
  logic [1:0]    retries;

  int cmp_n = 0;
  int err_n = 0;

  // Per-cycle expectations: {start, busy, batch_done, err, retries, jobs_ok}
  logic [9:0] exp_v   [NC];
  bit         done_at [NC];
  bit         iss_at  [NC];
  int         plan    [$];
  int         last_c;

  job_initiator #(.JOB_W(JW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .go(go), .num_jobs(num_jobs), .worker_done(worker_done),
    .start(start), .busy(busy), .batch_done(batch_done), .err(err),
    .jobs_ok(jobs_ok), .retries(retries)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {start, busy, batch_done, err, retries, jobs_ok};
  endfunction

  // Response delay of the next attempt in WAIT cycles (1..TO), 0 = worker stays silent.
  function automatic int next_k(input bit rnd);
    int k;
    if (plan.size() > 0) k = plan.pop_front();
    else if (rnd) k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO));
    else k = 0;
    return k;
  endfunction

  // Cycle 1 is the first cycle after the edge that accepts go.
  task automatic build(input int n, input bit rnd);
    int t, jobs, k, span;
    bit ok;
    for (int i = 0; i < NC; i++) begin
      exp_v[i] = '0; done_at[i] = 0; iss_at[i] = 0;
    end
    t = 1; jobs = 0; ok = 1;
    for (int j = 0; j < n && ok; j++) begin
      for (int a = 0; ; a++) begin
        k = next_k(rnd);
        span = (k != 0) ? k : int'(TO);
        iss_at[t] = 1;
        for (int c = t; c <= t + span; c++)
          exp_v[c] = {c == t, 1'b1, 1'b0, 1'b0, 2'(a), JW'(jobs)};
        if (k != 0) begin
          done_at[t + k] = 1;
          t += k + 1;
          jobs++;
          break;
        end
        t += TO + 1;
        if (a == int'(MR)) begin
          ok = 0;
          break;
        end
      end
    end
    exp_v[t]     = {1'b0, 1'b1, ok, !ok, ok ? 2'd0 : 2'(MR), JW'(jobs)};
    exp_v[t + 1] = {4'b0000, exp_v[t][5:0]};
    exp_v[t + 2] = exp_v[t + 1];
    last_c = t;
  endtask

  // Entered just after a negedge; drives go now (cycle 0) and checks cycles 1..last+2.
  task automatic run_batch(input string name, input int n, input bit rnd, input bit spur);
    build(n, rnd);
    go = 1'b1;
    num_jobs = JW'(n);
    worker_done = spur;
    for (int c = 1; c <= last_c + 2; c++) begin
      @(negedge clk);
      cmp_n++;
      if (obs() !== exp_v[c]) begin
        err_n++;
        $display("FAIL %s cycle %0d: got {start,busy,done,err,retries,jobs_ok}=%b required %b",
                 name, c, obs(), exp_v[c]);
      end
      go = spur && (c <= last_c);
      num_jobs = JW'($urandom_range(0, 15));
      worker_done = done_at[c] || (spur && (iss_at[c] || c >= last_c));
    end
    go = 1'b0;
    worker_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; num_jobs = '0; worker_done = 1'b0;
    repeat (3) @(negedge clk);
    cmp_n++;
    if (obs() !== 10'b0 || dut.state_name !== 48'("IDLE")) begin
      err_n++;
      $display("FAIL reset: got outputs %b state %s required all zero in IDLE", obs(), dut.state_name);
    end
    rst = 1'b0;
    @(negedge clk);
    cmp_n++;
    if (obs() !== 10'b0) begin
      err_n++;
      $display("FAIL reset_idle: got %b required 0", obs());
    end
  endtask

  task automatic test_single();
    plan = '{3};
    run_batch("single", 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    plan = '{1, 1, 1};
    run_batch("back_to_back", 3, 0, 0);
  endtask

  task automatic test_retry();
    plan = '{0, 5, 4};
    run_batch("retry", 2, 0, 0);
  endtask

  task automatic test_fail();
    plan = '{0, 0, 0};
    run_batch("fail", 2, 0, 0);
  endtask

  task automatic test_timeout_edge();
    plan = '{int'(TO), 0, 0, int'(TO)};
    run_batch("timeout_edge", 2, 0, 0);
  endtask

  task automatic test_zero_jobs();
    plan = {};
    run_batch("zero_jobs", 0, 0, 0);
  endtask

  task automatic test_spurious();
    plan = '{2, 1, 6};
    run_batch("spurious", 3, 0, 1);
  endtask

  task automatic test_reset_mid_wait();
    go = 1'b1; num_jobs = JW'(2);
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp_n++;
    if (obs() !== 10'b0 || dut.state_name !== 48'("IDLE")) begin
      err_n++;
      $display("FAIL reset_mid_wait: got %b state %s required all zero in IDLE", obs(), dut.state_name);
    end
    rst = 1'b0;
    worker_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      worker_done = 1'b0;
      cmp_n++;
      if (obs() !== 10'b0) begin
        err_n++;
        $display("FAIL reset_quiet cycle %0d: got %b required 0", c, obs());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      plan = {};
      run_batch("random", int'($urandom_range(1, 5)), 1, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_retry();
    test_fail();
    test_timeout_edge();
    test_zero_jobs();
    test_spurious();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
